// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/result sequencer: 4-bit ALU op
// codes, the sequencer state encoding, and op classification helpers.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NEG  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHRA = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1011;
  localparam logic [3:0] OP_ROR  = 4'b1100;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    EXEC,
    WB_LO,
    WB_HI
  } state_e;

  function automatic logic is_unary(input logic [3:0] op);
    return (op == OP_NEG) || (op == OP_NOT) || (op == OP_SHRA) ||
           (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL)  ||
           (op == OP_ROR);
  endfunction

  // MUL and DIV return a 64-bit result in two bus beats.
  function automatic logic is_wide(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_ROR;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Bus-side handshake of the ALU sequencer.
//   start/op/bus_in         : request and operand words from the bus master
//   bus_out/bus_out_valid   : result beat, out_hi marks the Z[63:32] beat
//   busy/done/zero_flag/err : operation status
interface alu_seq_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] bus_in;
  logic [31:0] bus_out;
  logic        bus_out_valid;
  logic        out_hi;
  logic        busy;
  logic        done;
  logic        zero_flag;
  logic        err;

  modport master (
    output start, op, bus_in,
    input  bus_out, bus_out_valid, out_hi, busy, done, zero_flag, err
  );

  modport slave (
    input  start, op, bus_in,
    output bus_out, bus_out_valid, out_hi, busy, done, zero_flag, err
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle operand/result sequencer for a combinational ALU.
// Collects A (start cycle) and B (next cycle, binary ops) from the bus,
// drives the ALU during EXEC, latches the 64-bit result into Z, then
// returns it as one beat, or LO then HI beats for MUL/DIV.
//   clk, clr        : clock, synchronous active-high reset
//   bus             : bus-side handshake (slave modport)
//   alu_a/b/ctrl    : ALU operand and control drive, zero outside EXEC
//   alu_out/zero    : ALU result and zero flag
module alu_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  alu_seq_if.slave    bus,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [63:0] alu_out,
  input  logic        alu_zero
);

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] y_q, y_d;
  logic [31:0] b_q, b_d;
  logic [63:0] z_q, z_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      op_q    <= '0;
      y_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      y_q     <= y_d;
      b_q     <= b_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    y_d               = y_q;
    b_d               = b_q;
    z_d               = z_q;
    zero_d            = zero_q;
    err_d             = err_q;
    alu_a             = '0;
    alu_b             = '0;
    alu_ctrl          = '0;
    bus.bus_out       = '0;
    bus.bus_out_valid = 1'b0;
    bus.out_hi        = 1'b0;
    bus.done          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d  = bus.op;
          y_d   = bus.bus_in;
          err_d = 1'b0;
          if (!is_legal(bus.op)) begin
            // Illegal op skips the ALU and returns a zero beat with err.
            z_d     = '0;
            err_d   = 1'b1;
            state_d = WB_LO;
          end else if (is_unary(bus.op)) begin
            state_d = EXEC;
          end else begin
            state_d = LOAD_B;
          end
        end
      end

      LOAD_B: begin
        b_d     = bus.bus_in;
        state_d = EXEC;
      end

      EXEC: begin
        alu_a    = y_q;
        alu_ctrl = op_q;
        alu_b    = is_unary(op_q) ? '0 : b_q;
        if ((op_q == OP_DIV) && (b_q == '0)) begin
          z_d    = '0;
          err_d  = 1'b1;
          zero_d = 1'b1;
        end else begin
          // Only MUL/DIV carry a meaningful upper word.
          z_d    = is_wide(op_q) ? alu_out : {32'h0, alu_out[31:0]};
          zero_d = alu_zero;
        end
        state_d = WB_LO;
      end

      WB_LO: begin
        bus.bus_out       = z_q[31:0];
        bus.bus_out_valid = 1'b1;
        if (is_wide(op_q)) begin
          state_d = WB_HI;
        end else begin
          bus.done = 1'b1;
          state_d  = IDLE;
        end
      end

      WB_HI: begin
        bus.bus_out       = z_q[63:32];
        bus.bus_out_valid = 1'b1;
        bus.out_hi        = 1'b1;
        bus.done          = 1'b1;
        state_d           = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.zero_flag = zero_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [63:0] alu_out;
  logic        alu_zero;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  alu_seq_if bus_if ();

  alu_seq dut (
    .clk      (clk),
    .clr      (clr),
    .bus      (bus_if),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out),
    .alu_zero (alu_zero)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU for the ops exercised here.
  logic [63:0] sa, sb;
  always_comb begin
    sa      = {{32{alu_a[31]}}, alu_a};
    sb      = {{32{alu_b[31]}}, alu_b};
    alu_out = '0;
    case (alu_ctrl)
      OP_ADD: alu_out = {32'h0, alu_a + alu_b};
      OP_SUB: alu_out = {32'h0, alu_a - alu_b};
      OP_AND: alu_out = {32'h0, alu_a & alu_b};
      OP_OR:  alu_out = {32'h0, alu_a | alu_b};
      OP_NEG: alu_out = {32'h0, 32'h0 - alu_a};
      OP_NOT: alu_out = {32'h0, ~alu_a};
      OP_MUL: alu_out = sa * sb;
      OP_DIV: begin
        if (alu_b == '0) alu_out = 64'hDEAD_BEEF_DEAD_BEEF;
        else alu_out = {32'($signed(alu_a) % $signed(alu_b)),
                        32'($signed(alu_a) / $signed(alu_b))};
      end
      default: alu_out = '0;
    endcase
  end
  assign alu_zero = (alu_out == '0);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // kind: 0 illegal, 1 unary, 2 binary one beat, 3 binary two beats
  typedef struct {
    string       name;
    logic [3:0]  op;
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zf;
    logic        er;
  } vec_t;

  // Entered at a negedge with the DUT idle; returns at the negedge of the
  // idle cycle after done so the next call starts back-to-back.
  task automatic run_op(input vec_t v);
    bus_if.start  = 1'b1;
    bus_if.op     = v.op;
    bus_if.bus_in = v.a;
    @(negedge clk);
    bus_if.start  = 1'b0;
    bus_if.op     = OP_ADD;
    if (v.kind == 0) begin
      chk({v.name, "_lo"},    64'(bus_if.bus_out), 64'(v.lo));
      chk({v.name, "_valid"}, 64'(bus_if.bus_out_valid), 64'd1);
      chk({v.name, "_done"},  64'(bus_if.done), 64'd1);
      chk({v.name, "_err"},   64'(bus_if.err), 64'(v.er));
    end else begin
      if (v.kind >= 2) begin
        // LOAD_B: B sampled now; bus_in then changes to a decoy value.
        bus_if.bus_in = v.b;
        chk({v.name, "_ldb_busy"}, 64'(bus_if.busy), 64'd1);
        chk({v.name, "_ldb_valid"}, 64'(bus_if.bus_out_valid), 64'd0);
        @(negedge clk);
      end
      bus_if.bus_in = 32'h1234_5678;
      chk({v.name, "_ex_a"}, 64'(alu_a), 64'(v.a));
      chk({v.name, "_ex_b"}, 64'(alu_b), (v.kind == 1) ? 64'd0 : 64'(v.b));
      chk({v.name, "_ex_ctrl"}, 64'(alu_ctrl), 64'(v.op));
      chk({v.name, "_ex_valid"}, 64'(bus_if.bus_out_valid), 64'd0);
      @(negedge clk);
      chk({v.name, "_lo"},     64'(bus_if.bus_out), 64'(v.lo));
      chk({v.name, "_lo_hi"},  64'(bus_if.out_hi), 64'd0);
      chk({v.name, "_lo_valid"}, 64'(bus_if.bus_out_valid), 64'd1);
      chk({v.name, "_lo_done"}, 64'(bus_if.done), (v.kind == 3) ? 64'd0 : 64'd1);
      chk({v.name, "_alu_idle"}, 64'(alu_a) | 64'(alu_b) | 64'(alu_ctrl), 64'd0);
      if (v.kind == 3) begin
        @(negedge clk);
        chk({v.name, "_hi"},       64'(bus_if.bus_out), 64'(v.hi));
        chk({v.name, "_hi_hi"},    64'(bus_if.out_hi), 64'd1);
        chk({v.name, "_hi_done"},  64'(bus_if.done), 64'd1);
      end
      chk({v.name, "_zf"},  64'(bus_if.zero_flag), 64'(v.zf));
      chk({v.name, "_err"}, 64'(bus_if.err), 64'(v.er));
    end
    @(negedge clk);
    chk({v.name, "_idle_busy"}, 64'(bus_if.busy), 64'd0);
    chk({v.name, "_idle_valid"}, 64'(bus_if.bus_out_valid), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_out"}, 64'(bus_if.bus_out), 64'd0);
    chk({tag, "_valid"},   64'(bus_if.bus_out_valid), 64'd0);
    chk({tag, "_out_hi"},  64'(bus_if.out_hi), 64'd0);
    chk({tag, "_busy"},    64'(bus_if.busy), 64'd0);
    chk({tag, "_done"},    64'(bus_if.done), 64'd0);
    chk({tag, "_zf"},      64'(bus_if.zero_flag), 64'd0);
    chk({tag, "_err"},     64'(bus_if.err), 64'd0);
    chk({tag, "_alu"},     64'(alu_a) | 64'(alu_b) | 64'(alu_ctrl), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"add",    OP_ADD, 2, 32'd5,        32'd3,        32'h0000_0008, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{"sub0",   OP_SUB, 2, 32'd5,        32'd5,        32'h0000_0000, 32'h0, 1'b1, 1'b0});
    vecs.push_back('{"and",    OP_AND, 2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{"mul",    OP_MUL, 3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{"mulneg", OP_MUL, 3, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{"div",    OP_DIV, 3, 32'h0000_000A, 32'h0000_0002, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{"div0",   OP_DIV, 3, 32'd7,        32'd0,        32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1});
    vecs.push_back('{"not",    OP_NOT, 1, 32'd5,        32'd0,        32'hFFFF_FFFA, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{"ill_e",  4'b1110, 0, 32'd9,       32'd0,        32'h0000_0000, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{"neg",    OP_NEG, 1, 32'd1,        32'd0,        32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0});
    vecs.push_back('{"ill_f",  4'b1111, 0, 32'd3,       32'd0,        32'h0000_0000, 32'h0, 1'b0, 1'b1});
    vecs.push_back('{"or",     OP_OR,  2, 32'hA000_0000, 32'h0000_0005, 32'hA000_0005, 32'h0, 1'b0, 1'b0});

    clr           = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.op     = '0;
    bus_if.bus_in = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    clr = 1'b0;
    @(negedge clk);

    // Directed vectors, issued back-to-back.
    foreach (vecs[i]) run_op(vecs[i]);

    // start held high while busy must not disturb a unary op in flight.
    bus_if.start  = 1'b1;
    bus_if.op     = OP_NOT;
    bus_if.bus_in = 32'd5;
    @(negedge clk);
    bus_if.op     = OP_ADD;
    bus_if.bus_in = 32'd99;
    chk("busy_ex_a", 64'(alu_a), 64'd5);
    @(negedge clk);
    chk("busy_lo", 64'(bus_if.bus_out), 64'hFFFF_FFFA);
    chk("busy_done", 64'(bus_if.done), 64'd1);
    bus_if.start = 1'b0;
    @(negedge clk);
    chk("busy_idle", 64'(bus_if.busy), 64'd0);

    // Leave zero_flag set, then abort a MUL during EXEC.
    run_op('{"div0b", OP_DIV, 3, 32'd7, 32'd0, 32'h0, 32'h0, 1'b1, 1'b1});
    bus_if.start  = 1'b1;
    bus_if.op     = OP_MUL;
    bus_if.bus_in = 32'h0001_0000;
    @(negedge clk);
    bus_if.start  = 1'b0;
    @(negedge clk);
    chk("abort_ex_ctrl", 64'(alu_ctrl), 64'(OP_MUL));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk_all_zero("abort");
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_beat", 64'(bus_if.bus_out_valid) | 64'(bus_if.done), 64'd0);
    end

    run_op(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle operand/result sequencer on the opposite side of the ALU from the datapath bus. It collects operands from the 32-bit bus, drives the combinational ALU's A/B/control inputs, and latches the 64-bit result into an internal Z register. It then returns the result to the bus as one beat, or as two beats (LO then HI) for multiply/divide. It owns the Y and Z register behaviour for one ALU operation at a time.

## Interface
- No parameters. Data width is fixed at 32 bits; the result width is fixed at 64 bits.
- clk  in  1  single clock; everything is on the rising edge
- clr  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  4  ALU control code, sampled with start
- bus_in  in  32  operand bus; carries A on the start cycle and B on the following cycle (binary ops only)
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_ctrl  out  4  to ALU control
- alu_out  in  64  ALU result
- alu_zero  in  1  ALU zero flag
- bus_out  out  32  result word
- bus_out_valid  out  1  bus_out holds a valid beat this cycle
- out_hi  out  1  the current beat is Z[63:32]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, coincident with the last result beat
- zero_flag  out  1  registered ALU zero from the last EXEC
- err  out  1  illegal op or divide by zero; valid while done=1

## Operation
- States: IDLE, LOAD_B, EXEC, WB_LO, WB_HI.
- Op codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0111 MUL, 1010 DIV: binary.
  - 0100 NEG, 0101 NOT, 0110 SHRA, 1000 SHL, 1001 SHR, 1011 ROL, 1100 ROR: unary.
  - 1101–1111: illegal.
- IDLE with start=1:
  - Capture op and bus_in into Y.
  - Next state is LOAD_B for binary ops, EXEC for unary ops, WB_LO for illegal ops.
  - For an illegal op, Z is cleared and err is set.
- LOAD_B: capture bus_in into the B register, then go to EXEC.
- EXEC:
  - Drive alu_a=Y, alu_ctrl=op, and alu_b=B register (binary) or 0 (unary).
  - Capture alu_out into Z and alu_zero into zero_flag, then go to WB_LO.
  - DIV with B=0: Z is forced to 0, err is set, and zero_flag is set to 1.
- WB_LO:
  - bus_out=Z[31:0], bus_out_valid=1, out_hi=0.
  - MUL/DIV go to WB_HI.
  - All other ops: done=1, then go to IDLE.
- WB_HI: bus_out=Z[63:32], bus_out_valid=1, out_hi=1, done=1, then go to IDLE.
- Result layout:
  - MUL: Z holds the signed 64-bit product.
  - DIV: Z[31:0] holds the quotient and Z[63:32] holds the remainder.
  - All other ops: Z[63:32]=0.
- Outside an active drive state, alu_a, alu_b and alu_ctrl are 0.
- start is ignored whenever busy=1; there is no queueing.
- err clears on the next accepted start. zero_flag holds until the next EXEC.

## Timing
- Reset (clr=1 at an edge):
  - State goes to IDLE.
  - Y, B and Z are cleared to 0.
  - All outputs are 0: bus_out, bus_out_valid, out_hi, busy, done, zero_flag, err, alu_a, alu_b, alu_ctrl.
- clr mid-operation aborts the operation; no done is issued and no partial beat appears after that edge.
- Let start be accepted at edge E0. The result beats and done then arrive as follows:
  - Binary single-word: WB_LO, with done, occupies E2–E3.
  - Binary MUL/DIV: WB_LO occupies E2–E3; WB_HI, with done, occupies E3–E4.
  - Unary: WB_LO, with done, occupies E1–E2.
  - Illegal op: WB_LO, with done and err, occupies E0–E1.
- B is sampled exactly one cycle after start.
- The ALU path is combinational and must settle within one clock; Z captures on the EXEC edge.
- busy falls on the edge that ends the done cycle. A start on that following cycle is accepted, giving back-to-back operations with no idle gap.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit op code localparams,
  - the state encoding,
  - helper functions is_unary(op), is_wide(op) (MUL/DIV) and is_legal(op).
- The ALU itself is instantiated outside this block and connected through the alu_* ports.
- No sub-module: the block is one FSM plus the Y, B and Z registers.

## Test plan
- ADD: A=5, B=3 -> bus_out=0x00000008 at E2, done at E2, zero_flag=0, err=0.
- SUB with zero result: A=5, B=5 -> bus_out=0x00000000, zero_flag=1.
- Multiply: MUL 0x00010000 × 0x00010000 -> LO beat 0x00000000 (out_hi=0) at E2, HI beat 0x00000001 (out_hi=1) at E3, done only at E3.
- Divide, normal and by zero:
  - DIV 0xA/0x2 -> LO beat 0x00000005, HI beat 0x00000000.
  - DIV 7/0 -> both beats 0, err=1.
- Unary and illegal ops:
  - NOT A=5 -> alu_b=0 during EXEC, bus_out=0xFFFFFFFA at E1 with done.
  - op=1110 -> done and err at E0, bus_out=0.
- Abort and back-to-back:
  - Assert clr during EXEC of a MUL -> no beats and no done; all outputs 0 on the next cycle.
  - Issue start the cycle after done -> accepted.
  - Issue start while busy -> ignored.
